// File: rtl/morse_letter_player.sv
// Morse letter player: plays one letter A-Z on a single LED with standard
// Morse timing (dot 1, dash 3, symbol gap 1, letter gap 3, word gap 7 units).
// Has a start/busy/done handshake, an invalid-letter error pulse and a beacon
// mode that replays the latched letter after each word gap.
module morse_letter_player #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] letter,
  input  logic       repeat_en,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, LGAP, WGAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic             last_unit;
  logic [2:0]       unit_cnt;
  logic [4:0]       letter_q;
  logic [2:0]       sym_len;
  logic [3:0]       sym_code;
  logic [1:0]       sym_idx;
  logic [6:0]       rom_word;

  // A mark lasts one unit for a dot and three units for a dash.
  function automatic logic [2:0] mark_units(input logic is_dash);
    return is_dash ? 3'd3 : 3'd1;
  endfunction

  assign tick      = (presc == CNT_W'(TICK_DIV - 1));
  assign last_unit = tick && (unit_cnt == 3'd1);

  // Letter ROM {len, code}: symbols sent LSB first, 0 = dot, 1 = dash.
  always_comb begin
    rom_word = 7'd0;
    case (letter_q)
      5'd0:  rom_word = {3'd2, 4'b0010}; // A .-
      5'd1:  rom_word = {3'd4, 4'b0001}; // B -...
      5'd2:  rom_word = {3'd4, 4'b0101}; // C -.-.
      5'd3:  rom_word = {3'd3, 4'b0001}; // D -..
      5'd4:  rom_word = {3'd1, 4'b0000}; // E .
      5'd5:  rom_word = {3'd4, 4'b0100}; // F ..-.
      5'd6:  rom_word = {3'd3, 4'b0011}; // G --.
      5'd7:  rom_word = {3'd4, 4'b0000}; // H ....
      5'd8:  rom_word = {3'd2, 4'b0000}; // I ..
      5'd9:  rom_word = {3'd4, 4'b1110}; // J .---
      5'd10: rom_word = {3'd3, 4'b0101}; // K -.-
      5'd11: rom_word = {3'd4, 4'b0010}; // L .-..
      5'd12: rom_word = {3'd2, 4'b0011}; // M --
      5'd13: rom_word = {3'd2, 4'b0001}; // N -.
      5'd14: rom_word = {3'd3, 4'b0111}; // O ---
      5'd15: rom_word = {3'd4, 4'b0110}; // P .--.
      5'd16: rom_word = {3'd4, 4'b1011}; // Q --.-
      5'd17: rom_word = {3'd3, 4'b0010}; // R .-.
      5'd18: rom_word = {3'd3, 4'b0000}; // S ...
      5'd19: rom_word = {3'd1, 4'b0001}; // T -
      5'd20: rom_word = {3'd3, 4'b0100}; // U ..-
      5'd21: rom_word = {3'd4, 4'b1000}; // V ...-
      5'd22: rom_word = {3'd3, 4'b0110}; // W .--
      5'd23: rom_word = {3'd4, 4'b1001}; // X -..-
      5'd24: rom_word = {3'd4, 4'b1101}; // Y -.--
      5'd25: rom_word = {3'd4, 4'b0011}; // Z --..
      default: rom_word = 7'd0;
    endcase
  end

  // Unit prescaler: held at zero until play starts, then wraps every TICK_DIV cycles.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc <= '0;
    end else if (state == IDLE || state == LOAD || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  // Main sequencer: walks the latched symbols and drives the registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      led      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      unit_cnt <= 3'd0;
      letter_q <= 5'd0;
      sym_len  <= 3'd0;
      sym_code <= 4'd0;
      sym_idx  <= 2'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (tick) begin
        unit_cnt <= unit_cnt - 3'd1;
      end
      case (state)
        IDLE: begin
          led  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (letter < 5'd26) begin
              letter_q <= letter;
              busy     <= 1'b1;
              state    <= LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          sym_len  <= rom_word[6:4];
          sym_code <= rom_word[3:0];
          sym_idx  <= 2'd0;
          unit_cnt <= mark_units(rom_word[0]);
          led      <= 1'b1;
          state    <= MARK;
        end
        MARK: begin
          if (last_unit) begin
            led <= 1'b0;
            if ({1'b0, sym_idx} == sym_len - 3'd1) begin
              unit_cnt <= 3'd3;
              state    <= LGAP;
            end else begin
              unit_cnt <= 3'd1;
              state    <= SPACE;
            end
          end
        end
        SPACE: begin
          if (last_unit) begin
            sym_idx  <= sym_idx + 2'd1;
            unit_cnt <= mark_units(sym_code[sym_idx + 2'd1]);
            led      <= 1'b1;
            state    <= MARK;
          end
        end
        LGAP: begin
          if (last_unit) begin
            if (repeat_en) begin
              unit_cnt <= 3'd4;
              state    <= WGAP;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        WGAP: begin
          if (last_unit) begin
            sym_idx  <= 2'd0;
            unit_cnt <= mark_units(sym_code[0]);
            led      <= 1'b1;
            state    <= MARK;
          end
        end
        default: begin
          led   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
